// File: rtl/micro_tile_pkg.sv
// Shared types and helpers for the micro-tile slot sequencer.
package micro_tile_pkg;

  localparam int unsigned NumTilesDefault = 4;
  localparam int unsigned SelWDefault     = 2;

  typedef enum logic [1:0] {
    StHold,
    StRun,
    StQuiesce
  } state_e;

  function automatic logic [31:0] onehot(input int unsigned sel);
    return 32'd1 << sel;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/micro_tile_sequencer.sv
// Schedules the shared micro-tile slot: manual or round-robin selection with a
// stop-clocks / hold-in-reset / run handover. All outputs are registered.
module micro_tile_sequencer
  import micro_tile_pkg::*;
#(
  parameter int unsigned NUM_TILES = NumTilesDefault,
  parameter int unsigned SEL_W     = SelWDefault,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned DWELL_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     sel_req,
  input  logic                 auto_mode,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [NUM_TILES-1:0] tile_clk_en,
  output logic [NUM_TILES-1:0] tile_rst_n,
  output logic [SEL_W-1:0]     sel_active,
  output logic                 out_valid,
  output logic                 switching
);

  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [SEL_W:0]   sync_q;
  logic             auto_sync;
  logic [SEL_W-1:0] sel_sync;

  sync_2ff #(
    .WIDTH(SEL_W + 1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   ({auto_mode, sel_req}),
    .q_o   (sync_q)
  );

  assign auto_sync = sync_q[SEL_W];
  assign sel_sync  = sync_q[SEL_W-1:0];

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [SEL_W-1:0]   sel_active_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               auto_prev_q;

  logic               auto_edge;
  logic               sel_ok;
  logic               dwell_hit;
  logic [SEL_W-1:0]   next_tile;
  logic [NUM_TILES-1:0] tile_mask_d;
  logic [NUM_TILES-1:0] clk_en_d, rst_n_d;
  logic               out_valid_d, switching_d;

  assign auto_edge = auto_sync ^ auto_prev_q;
  assign sel_ok    = 32'(sel_sync) < NUM_TILES;
  // Compare against the live dwell so a shrunk dwell switches on the next cycle.
  assign dwell_hit = dwell_cnt_q >= (dwell - DWELL_W'(1));
  assign next_tile = (32'(sel_active) == NUM_TILES - 1) ? '0 : sel_active + 1'b1;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    sel_active_d = sel_active;
    hold_cnt_d   = hold_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;

    if (auto_edge) dwell_cnt_d = '0;

    case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldW'(RST_HOLD - 1)) begin
          state_d     = StRun;
          hold_cnt_d  = '0;
          dwell_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (auto_sync) begin
          if (!auto_edge && (dwell != '0)) begin
            if (dwell_hit) begin
              target_d = next_tile;
              state_d  = StQuiesce;
            end else begin
              dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
          end
        end else if ((sel_sync != sel_active) && sel_ok) begin
          target_d = sel_sync;
          state_d  = StQuiesce;
        end
      end
      StQuiesce: begin
        sel_active_d = target_q;
        hold_cnt_d   = '0;
        state_d      = StHold;
      end
      default: state_d = StHold;
    endcase
  end

  // Outputs are decoded from next state so they register alongside it.
  always_comb begin
    tile_mask_d = NUM_TILES'(onehot(32'(sel_active_d)));
    clk_en_d    = '0;
    rst_n_d     = '0;
    out_valid_d = 1'b0;
    switching_d = 1'b1;
    case (state_d)
      StRun: begin
        clk_en_d    = tile_mask_d;
        rst_n_d     = tile_mask_d;
        out_valid_d = 1'b1;
        switching_d = 1'b0;
      end
      StHold:  clk_en_d = tile_mask_d;
      default: clk_en_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      sel_active  <= '0;
      target_q    <= '0;
      hold_cnt_q  <= '0;
      dwell_cnt_q <= '0;
      auto_prev_q <= 1'b0;
      tile_clk_en <= NUM_TILES'(1);
      tile_rst_n  <= '0;
      out_valid   <= 1'b0;
      switching   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sel_active  <= sel_active_d;
      target_q    <= target_d;
      hold_cnt_q  <= hold_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      auto_prev_q <= auto_sync;
      tile_clk_en <= clk_en_d;
      tile_rst_n  <= rst_n_d;
      out_valid   <= out_valid_d;
      switching   <= switching_d;
    end
  end

endmodule

// File: tb/tb_micro_tile_sequencer.sv
// Scoreboard bench: a tenure-level model predicts each RUN tenure (tile, length,
// preceding gap); a monitor reconstructs tenures from the outputs and compares.
module tb_micro_tile_sequencer;

  localparam int unsigned NT = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned RH = 4;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] sel_req = '0;
  logic          auto_mode = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [NT-1:0] tile_clk_en;
  logic [NT-1:0] tile_rst_n;
  logic [SW-1:0] sel_active;
  logic          out_valid;
  logic          switching;

  always #5 clk = ~clk;

  micro_tile_sequencer #(
    .NUM_TILES(NT),
    .SEL_W    (SW),
    .RST_HOLD (RH),
    .DWELL_W  (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_req    (sel_req),
    .auto_mode  (auto_mode),
    .dwell      (dwell),
    .tile_clk_en(tile_clk_en),
    .tile_rst_n (tile_rst_n),
    .sel_active (sel_active),
    .out_valid  (out_valid),
    .switching  (switching)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned tile;
    int unsigned len;
    int unsigned gap;
  } tenure_t;

  tenure_t exp_q[$];

  // Reference model: a tile runs until a switch rule fires; each handover costs
  // one quiesce cycle plus RH hold cycles, the first tenure after reset only RH.
  int unsigned m_tile = 0, m_next = 0, m_left = RH, m_len = 0, m_gap = RH, m_age = 0;
  logic [SW-1:0] s1_req = '0, s2_req = '0;
  logic          s1_auto = 1'b0, s2_auto = 1'b0, m_auto_prev = 1'b0;

  initial begin : model
    bit sw;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_tile = 0; m_next = 0; m_left = RH; m_len = 0; m_gap = RH; m_age = 0;
        s1_req = '0; s2_req = '0; s1_auto = 1'b0; s2_auto = 1'b0; m_auto_prev = 1'b0;
      end else begin
        if (m_left > 0) begin
          if (m_left == RH + 1) m_tile = m_next;
          m_left--;
          if (m_left == 0) begin
            m_len = 0;
            m_age = 0;
          end
        end else begin
          m_len++;
          sw = 1'b0;
          if (s2_auto != m_auto_prev) m_age = 0;
          if (s2_auto) begin
            if ((s2_auto == m_auto_prev) && (dwell != 0)) begin
              if (m_age + 1 >= int'(dwell)) begin
                sw = 1'b1;
                m_next = (m_tile + 1) % NT;
              end else begin
                m_age++;
              end
            end
          end else if (32'(s2_req) != m_tile) begin
            sw = 1'b1;
            m_next = 32'(s2_req);
          end
          if (sw) begin
            exp_q.push_back('{tile: m_tile, len: m_len, gap: m_gap});
            m_gap  = RH + 1;
            m_left = RH + 1;
          end
        end
        m_auto_prev = s2_auto;
        s2_req = s1_req;  s1_req = sel_req;
        s2_auto = s1_auto; s1_auto = auto_mode;
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  bit            in_run = 1'b0;
  int unsigned   run_len = 0, gap = 0, start_gap = 0, n_ten = 0;
  logic [SW-1:0] run_sel;
  logic [NT-1:0] oh;

  initial begin : monitor
    tenure_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_switching", switching, 1);
        check("rst_clk_en", tile_clk_en, 4'b0001);
        check("rst_tile_rst_n", tile_rst_n, 4'b0000);
        check("rst_sel_active", sel_active, 0);
        in_run = 1'b0;
        gap = 0;
      end else begin
        check("clk_en_onehot0", $countones(tile_clk_en) <= 1, 1);
        if (out_valid) begin
          oh = 4'b0001 << sel_active;
          check("run_clk_en", tile_clk_en, oh);
          check("run_tile_rst_n", tile_rst_n, oh);
          check("run_switching", switching, 0);
          if (!in_run) begin
            in_run = 1'b1;
            run_len = 0;
            run_sel = sel_active;
            start_gap = gap;
          end else begin
            check("run_sel_stable", sel_active, run_sel);
          end
          run_len++;
        end else begin
          check("sw_switching", switching, 1);
          check("sw_tile_rst_n", tile_rst_n, 4'b0000);
          if (in_run) begin
            in_run = 1'b0;
            if (exp_q.size() == 0) begin
              check("tenure_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              n_ten++;
              check("tenure_tile", run_sel, e.tile);
              check("tenure_len", run_len, e.len);
              check("tenure_gap", start_gap, e.gap);
            end
            gap = 0;
          end
          gap++;
        end
      end
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned n;
    bit          found;
    // 1: reset release, tile 0 comes up
    cyc(5);
    rst_n = 1'b1;
    cyc(12);

    // 2: manual switch 0 -> 2 and its latency in edges
    sel_req = 2;
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid && sel_active == 2) found = 1'b1;
    end
    check("manual_latency", n, RH + 4);
    cyc(5);

    // 3: auto round-robin with dwell 5
    auto_mode = 1'b1; dwell = 5;
    cyc(60);

    // 4: dwell 0 never advances, then dwell 3
    dwell = 0;
    cyc(1000);
    dwell = 3;
    cyc(40);

    // 5: a request glitch inside HOLD must not cause a switch
    auto_mode = 1'b0; sel_req = 0;
    cyc(20);
    sel_req = 1;
    n = 0; found = 1'b0;
    while (n < 30 && !found) begin
      @(negedge clk); n++;
      if (switching && tile_clk_en == 4'b0010) found = 1'b1;
    end
    check("hold_tile1_seen", found, 1);
    cyc(1); sel_req = 3;
    cyc(1); sel_req = 1;
    cyc(20);
    sel_req = 3;
    cyc(2); sel_req = 1;
    cyc(30);

    // Randomized mode, request and dwell changes
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: sel_req = SW'($urandom_range(0, NT - 1));
        1: auto_mode = ~auto_mode;
        2: dwell = DW'($urandom_range(0, 6));
        default: ;
      endcase
      cyc($urandom_range(1, 10));
    end

    // 6: asynchronous reset during HOLD of tile 3
    auto_mode = 1'b0; sel_req = 0;
    cyc(25);
    sel_req = 3;
    n = 0; found = 1'b0;
    while (n < 30 && !found) begin
      @(negedge clk); n++;
      if (switching && tile_clk_en == 4'b1000) found = 1'b1;
    end
    check("hold_tile3_seen", found, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_clk_en", tile_clk_en, 4'b0001);
    check("async_rst_sel", sel_active, 0);
    sel_req = 0;
    cyc(3);
    rst_n = 1'b1;
    n = 0; found = 1'b0;
    while (n < 20 && !found) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    check("post_rst_latency", n, RH);
    check("post_rst_sel", sel_active, 0);
    cyc(5);
    sel_req = 1;
    cyc(30);

    check("scoreboard_drained", exp_q.size(), 0);
    check("tenures_seen_min", n_ten >= 10, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
